// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel registered multiplexer with round-robin arbitration.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (channel 0 highest).
module rr_mux_reg #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // Handshake: a beat moves on a rising edge where its valid and ready are both high.
  // in_ready is one-hot or zero; out_valid stays high with stable data until out_ready.
  logic             load;
  logic             any_valid;
  logic [N-1:0]     lo_mask;
  logic [N-1:0]     hi_req;
  logic [N-1:0]     req_sel;
  logic [N-1:0]     grant_oh;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign lo_mask = '0;
`else
  logic [SELW-1:0] ptr;
  // Channels below ptr are only considered when nothing at or above ptr requests.
  assign lo_mask = (N'(1) << ptr) - N'(1);
`endif

  assign hi_req    = in_valid & ~lo_mask;
  assign req_sel   = (|hi_req) ? hi_req : in_valid;
  assign grant_oh  = req_sel & (~req_sel + N'(1));
  assign any_valid = |in_valid;
  assign load      = ~out_valid | out_ready;
  assign in_ready  = (load && !rst) ? grant_oh : '0;

  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) begin
        grant      = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
`ifndef RR_MUX_FIXED_PRIO_EN
        ptr       <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed and random checks of rr_mux_reg against a behavioural model
// plus an in-order beat scoreboard.
module tb_rr_mux_reg;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = $clog2(N);
  localparam int W     = SELW + WIDTH;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       in_valid = '0;
  logic [N*WIDTH-1:0] in_data  = '0;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready = 1'b0;

  always #5 clk = ~clk;

  rr_mux_reg #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [SELW-1:0]  m_sel   = '0;
  int               m_ptr   = 0;
  int               m_g;
  logic [N-1:0]     exp_ready;
  logic [W-1:0]     exp_q[$];

  function automatic int start_of(input int p);
`ifdef RR_MUX_FIXED_PRIO_EN
    return 0;
`else
    return p;
`endif
  endfunction

  // First requesting channel found walking upward from start, wrapping; -1 if none.
  function automatic int find_grant(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always_comb m_g = find_grant(in_valid, start_of(m_ptr));

  always_comb begin
    exp_ready = '0;
    if (!rst && (!m_valid || out_ready) && m_g >= 0) exp_ready = N'(1) << m_g;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= '0;
      m_ptr   <= 0;
      exp_q.delete();
    end else if (!m_valid || out_ready) begin
      if (m_g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[m_g*WIDTH +: WIDTH];
        m_sel   <= SELW'(m_g);
        m_ptr   <= (m_g + 1) % N;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_sel",   32'(out_sel),   32'(m_sel));
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_beat", 32'({out_sel, out_data}), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < N; i++) begin
        if (in_ready[i] && in_valid[i]) exp_q.push_back({SELW'(i), in_data[i*WIDTH +: WIDTH]});
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [7:0] tbl[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_sel",   32'(out_sel),   32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef RR_MUX_FIXED_PRIO_EN
    @(negedge clk); check("fp_first_ready", 32'(in_ready), 32'h1);
    repeat (3) begin
      @(negedge clk);
      check("fp_sel",  32'(out_sel),  32'd0);
      check("fp_data", 32'(out_data), 32'h11);
    end
    tick(); in_valid = 4'hE;
    @(negedge clk); check("fp_ready_drop0", 32'(in_ready), 32'h2);
    @(negedge clk); check("fp_sel_drop0", 32'(out_sel), 32'd1);
    check("fp_data_drop0", 32'(out_data), 32'h22);
`else
    // round-robin with all channels valid
    @(negedge clk); check("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_sel",  32'(out_sel),  32'(k % 4));
      check("rr_data", 32'(out_data), 32'(tbl[k % 4]));
    end
    // backpressure holding the channel-1 beat
    tick(); out_ready = 1'b0; in_valid = 4'b1010;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready),  32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'h22);
      check("bp_sel",   32'(out_sel),   32'd1);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk); check("bp_release_ready", 32'(in_ready), 32'h8);
    @(negedge clk); check("bp_next_sel", 32'(out_sel), 32'd3);
    check("bp_next_data", 32'(out_data), 32'h44);
    // sparse requests and pointer wrap
    tick(); in_valid = 4'b1000;
    @(negedge clk); check("sp_ready3", 32'(in_ready), 32'h8);
    tick(); in_valid = 4'b0001;
    @(negedge clk); check("sp_sel3", 32'(out_sel), 32'd3);
    check("sp_ready0", 32'(in_ready), 32'h1);
    tick(); in_valid = 4'b0000;
    @(negedge clk); check("sp_sel0", 32'(out_sel), 32'd0);
    check("sp_data0", 32'(out_data), 32'h11);
    // idle cycle, then ptr=1 must pick channel 2 over channel 0
    tick(); in_valid = 4'b0101; in_data[2*WIDTH +: WIDTH] = 8'hA5;
    @(negedge clk); check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data_held", 32'(out_data), 32'h11);
    check("pt_ready2", 32'(in_ready), 32'h4);
    @(negedge clk); check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", 32'(out_data), 32'hA5);
    check("pt_sel",  32'(out_sel),  32'd2);
    // reset in the middle of a held beat
    tick(); out_ready = 1'b0; in_valid = 4'hF;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2; rst = 1'b1; #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_sel",   32'(out_sel),   32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    tick(); rst = 1'b0; out_ready = 1'b1; in_data[2*WIDTH +: WIDTH] = 8'h33;
    @(negedge clk); check("post_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk); check("post_rst_sel", 32'(out_sel), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h11);
`endif

    // random traffic, checked by the model and scoreboard
    for (int c = 0; c < 300; c++) begin
      tick();
      in_valid  = N'($urandom_range(0, (1 << N) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
    end

    tick(); in_valid = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
